cordic_rr_scheduler: RTL and testbench

//  Shares one pipelined vectoring CORDIC (fixed latency, no backpressure) between NUM_REQ requesters.

---
 rtl/cordic_rr_scheduler.sv | 165 ++++++++++++++++
 tb/tb_cordic_rr_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rr_scheduler.sv
// Round-robin front-end sharing one pipelined vectoring CORDIC between NUM_REQ requesters.
// A tag pipeline matched to the CORDIC latency routes each result back to its owner.
module cordic_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int XY_WIDTH       = 16,
    parameter int Z_WIDTH        = 16,
    parameter int CORDIC_LATENCY = 18
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_hold,
    input  logic [NUM_REQ-1:0]                    i_req_valid,
    output logic [NUM_REQ-1:0]                    o_req_ready,
    input  logic [NUM_REQ*XY_WIDTH-1:0]           i_req_x,
    input  logic [NUM_REQ*XY_WIDTH-1:0]           i_req_y,
    input  logic [NUM_REQ*Z_WIDTH-1:0]            i_req_z,
    output logic                                  o_cordic_en,
    output logic                                  o_cordic_rst,
    output logic                                  o_cordic_valid_in,
    output logic [XY_WIDTH-1:0]                   o_cordic_x_in,
    output logic [XY_WIDTH-1:0]                   o_cordic_y_in,
    output logic [Z_WIDTH-1:0]                    o_cordic_z_in,
    input  logic                                  i_cordic_valid_out,
    input  logic [XY_WIDTH-1:0]                   i_cordic_x_out,
    input  logic [XY_WIDTH-1:0]                   i_cordic_y_out,
    input  logic [Z_WIDTH-1:0]                    i_cordic_z_out,
    output logic [NUM_REQ-1:0]                    o_res_valid,
    output logic [XY_WIDTH-1:0]                   o_res_x,
    output logic [XY_WIDTH-1:0]                   o_res_y,
    output logic [Z_WIDTH-1:0]                    o_res_z,
    output logic [$clog2(CORDIC_LATENCY+1)-1:0]   o_inflight,
    output logic                                  o_sync_err
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(CORDIC_LATENCY+1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [ID_W-1:0]           r_ptr;
    logic                      r_valid_in;
    logic [ID_W-1:0]           r_id_in;
    logic [XY_WIDTH-1:0]       r_x_in;
    logic [XY_WIDTH-1:0]       r_y_in;
    logic [Z_WIDTH-1:0]        r_z_in;
    logic [CORDIC_LATENCY-1:0] r_tag_valid;
    logic [ID_W-1:0]           r_tag_id [CORDIC_LATENCY];
    logic [CNT_W-1:0]          r_inflight;
    logic [NUM_REQ-1:0]        r_res_valid;
    logic [XY_WIDTH-1:0]       r_res_x;
    logic [XY_WIDTH-1:0]       r_res_y;
    logic [Z_WIDTH-1:0]        r_res_z;
    logic                      r_sync_err;

    logic [ID_W-1:0]           w_cand [NUM_REQ];
    logic                      w_grant_found;
    logic [ID_W-1:0]           w_grant_id;
    logic                      w_transfer;
    logic [ID_W-1:0]           w_ptr_next;
    logic [XY_WIDTH-1:0]       w_sel_x;
    logic [XY_WIDTH-1:0]       w_sel_y;
    logic [Z_WIDTH-1:0]        w_sel_z;
    logic                      w_tag_out_valid;
    logic [ID_W-1:0]           w_tag_out_id;

    // Candidate order starts at the pointer and wraps, so the first hit is the round-robin winner.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand[i] = ID_W'((int'(r_ptr) + i) % NUM_REQ);
        end
    end

    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_grant_found && i_req_valid[w_cand[i]]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_cand[i];
            end
        end
    end

    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        w_sel_z = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == w_grant_id) begin
                w_sel_x = i_req_x[k*XY_WIDTH +: XY_WIDTH];
                w_sel_y = i_req_y[k*XY_WIDTH +: XY_WIDTH];
                w_sel_z = i_req_z[k*Z_WIDTH +: Z_WIDTH];
            end
        end
    end

    assign w_transfer      = w_grant_found & i_rst_n & ~i_hold;
    assign w_ptr_next      = (w_grant_id == ID_W'(NUM_REQ-1)) ? '0 : w_grant_id + 1'b1;
    assign w_tag_out_valid = r_tag_valid[CORDIC_LATENCY-1];
    assign w_tag_out_id    = r_tag_id[CORDIC_LATENCY-1];

    // Every state element advances only with the CORDIC enable, so hold freezes the whole loop in step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_valid_in  <= 1'b0;
            r_id_in     <= '0;
            r_x_in      <= '0;
            r_y_in      <= '0;
            r_z_in      <= '0;
            r_tag_valid <= '0;
            for (int k = 0; k < CORDIC_LATENCY; k++) begin
                r_tag_id[k] <= '0;
            end
            r_inflight  <= '0;
            r_res_valid <= '0;
            r_res_x     <= '0;
            r_res_y     <= '0;
            r_res_z     <= '0;
            r_sync_err  <= 1'b0;
        end else if (!i_hold) begin
            r_valid_in <= w_transfer;
            if (w_transfer) begin
                r_ptr   <= w_ptr_next;
                r_id_in <= w_grant_id;
                r_x_in  <= w_sel_x;
                r_y_in  <= w_sel_y;
                r_z_in  <= w_sel_z;
            end
            r_tag_valid <= {r_tag_valid[CORDIC_LATENCY-2:0], r_valid_in};
            r_tag_id[0] <= r_id_in;
            for (int k = 1; k < CORDIC_LATENCY; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
            case ({r_valid_in, w_tag_out_valid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            r_res_valid <= w_tag_out_valid ? (ONE << w_tag_out_id) : '0;
            if (w_tag_out_valid) begin
                r_res_x <= i_cordic_x_out;
                r_res_y <= i_cordic_y_out;
                r_res_z <= i_cordic_z_out;
            end
            if (i_cordic_valid_out != w_tag_out_valid) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    assign o_req_ready       = w_transfer ? (ONE << w_grant_id) : '0;
    assign o_cordic_en       = ~i_hold;
    assign o_cordic_rst      = ~i_rst_n;
    assign o_cordic_valid_in = r_valid_in & ~i_hold;
    assign o_cordic_x_in     = r_x_in;
    assign o_cordic_y_in     = r_y_in;
    assign o_cordic_z_in     = r_z_in;
    assign o_res_valid       = i_hold ? '0 : r_res_valid;
    assign o_res_x           = r_res_x;
    assign o_res_y           = r_res_y;
    assign o_res_z           = r_res_z;
    assign o_inflight        = r_inflight;
    assign o_sync_err        = r_sync_err;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: a stand-in CORDIC delay line with a simple data transform,
// and a transaction-level model that predicts grants, issue, results, inflight and sync_err.
module tb_cordic_rr_scheduler;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int L  = 18;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           hold;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_x, req_y, req_z;
    logic           cordic_en, cordic_rst, cordic_valid_in;
    logic [W-1:0]   cordic_x_in, cordic_y_in, cordic_z_in;
    logic           cordic_valid_out;
    logic [W-1:0]   cordic_x_out, cordic_y_out, cordic_z_out;
    logic [N-1:0]   res_valid;
    logic [W-1:0]   res_x, res_y, res_z;
    logic [4:0]     inflight;
    logic           sync_err;
    logic           dropValid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    cordic_rr_scheduler #(.NUM_REQ(N), .XY_WIDTH(W), .Z_WIDTH(W), .CORDIC_LATENCY(L)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_x(req_x), .i_req_y(req_y), .i_req_z(req_z),
        .o_cordic_en(cordic_en), .o_cordic_rst(cordic_rst),
        .o_cordic_valid_in(cordic_valid_in),
        .o_cordic_x_in(cordic_x_in), .o_cordic_y_in(cordic_y_in), .o_cordic_z_in(cordic_z_in),
        .i_cordic_valid_out(cordic_valid_out),
        .i_cordic_x_out(cordic_x_out), .i_cordic_y_out(cordic_y_out), .i_cordic_z_out(cordic_z_out),
        .o_res_valid(res_valid), .o_res_x(res_x), .o_res_y(res_y), .o_res_z(res_z),
        .o_inflight(inflight), .o_sync_err(sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in CORDIC: fixed latency L, frozen by enable, result = (x+7, y^5A5A, z-x).
    logic [L-1:0] fv;
    logic [W-1:0] fx [L];
    logic [W-1:0] fy [L];
    logic [W-1:0] fz [L];

    always @(posedge clk or posedge cordic_rst) begin
        if (cordic_rst) begin
            fv <= '0;
            for (int k = 0; k < L; k++) begin
                fx[k] <= '0; fy[k] <= '0; fz[k] <= '0;
            end
        end else if (cordic_en) begin
            fv    <= {fv[L-2:0], cordic_valid_in};
            fx[0] <= cordic_x_in + 16'd7;
            fy[0] <= cordic_y_in ^ 16'h5A5A;
            fz[0] <= cordic_z_in - cordic_x_in;
            for (int k = 1; k < L; k++) begin
                fx[k] <= fx[k-1]; fy[k] <= fy[k-1]; fz[k] <= fz[k-1];
            end
        end
    end

    assign cordic_valid_out = fv[L-1] & ~dropValid;
    assign cordic_x_out     = fx[L-1];
    assign cordic_y_out     = fy[L-1];
    assign cordic_z_out     = fz[L-1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] rv, input logic h);
        @(posedge clk);
        #1;
        dropValid = 1'b0;
        req_valid = rv;
        hold      = h;
        req_x     = {$urandom, $urandom};
        req_y     = {$urandom, $urandom};
        req_z     = {$urandom, $urandom};
    endtask

    // Transaction model: each accepted op is stamped with the count of un-held cycles at transfer.
    typedef struct {
        int         n;
        int         id;
        logic [W-1:0] x, y, z;
    } rec_t;

    rec_t recs[$];
    int   aNow       = 0;
    int   ptrM       = 0;
    bit   syncErrExp = 1'b0;

    function automatic int expGrant(input logic [N-1:0] rv, input int p);
        for (int i = 0; i < N; i++) begin
            if (rv[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic int findRec(input int n);
        for (int k = 0; k < recs.size(); k++) begin
            if (recs[k].n == n) return k;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compareProc
        int g, iv, ir, cnt;
        logic [N-1:0] expReady, expRes;
        bit tagValidM;
        if (!rst_n) begin
            checkOutput("rst_ready", req_ready, 0);
            checkOutput("rst_res_valid", res_valid, 0);
            checkOutput("rst_valid_in", cordic_valid_in, 0);
            checkOutput("rst_inflight", inflight, 0);
            checkOutput("rst_sync_err", sync_err, 0);
            checkOutput("rst_res_xyz", {res_x, res_y, res_z}, 0);
            checkOutput("rst_cordic_rst", cordic_rst, 1);
            recs.delete();
            ptrM       = 0;
            syncErrExp = 1'b0;
        end else begin
            g        = expGrant(req_valid, ptrM);
            expReady = (hold || g < 0) ? '0 : (N'(1) << g);
            checkOutput("req_ready", req_ready, expReady);
            checkOutput("cordic_en", cordic_en, !hold);
            checkOutput("cordic_rst", cordic_rst, 0);

            iv = findRec(aNow - 1);
            checkOutput("cordic_valid_in", cordic_valid_in, (!hold && iv >= 0));
            if (!hold && iv >= 0) begin
                checkOutput("cordic_xyz_in", {cordic_x_in, cordic_y_in, cordic_z_in},
                            {recs[iv].x, recs[iv].y, recs[iv].z});
            end

            ir     = findRec(aNow - (L + 2));
            expRes = (!hold && ir >= 0) ? (N'(1) << recs[ir].id) : '0;
            checkOutput("res_valid", res_valid, expRes);
            if (!hold && ir >= 0) begin
                checkOutput("res_xyz", {res_x, res_y, res_z},
                            {W'(recs[ir].x + 16'd7), W'(recs[ir].y ^ 16'h5A5A), W'(recs[ir].z - recs[ir].x)});
            end

            cnt = 0;
            foreach (recs[k]) if (recs[k].n + 2 <= aNow && aNow <= recs[k].n + L + 1) cnt++;
            checkOutput("inflight", inflight, cnt);
            checkOutput("sync_err", sync_err, syncErrExp);

            tagValidM = (findRec(aNow - (L + 1)) >= 0);
            if (!hold) begin
                if (cordic_valid_out !== tagValidM) syncErrExp = 1'b1;
                if (g >= 0) begin
                    recs.push_back('{aNow, g, req_x[g*W +: W], req_y[g*W +: W], req_z[g*W +: W]});
                    ptrM = (g + 1) % N;
                end
                aNow++;
                while (recs.size() > 0 && recs[0].n < aNow - (L + 2)) void'(recs.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0;
        bit seen;
        rst_n = 1'b0; hold = 1'b0; req_valid = '0; dropValid = 1'b0;
        req_x = '0; req_y = '0; req_z = '0;
        repeat (3) applyStimulus(0, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0);

        // Single op from requester 2.
        applyStimulus(4'b0100, 0);
        req_x[32 +: 16] = 16'd3000; req_y[32 +: 16] = 16'd4000; req_z[32 +: 16] = 16'd0;
        #1 checkOutput("t2_ready", req_ready, 4'b0100);
        repeat (L + 2) applyStimulus(0, 0);
        #1 checkOutput("t2_res_valid", res_valid, 4'b0100);
        checkOutput("t2_res_x", res_x, 16'd3007);
        checkOutput("t2_res_y", res_y, 16'h55FA);
        checkOutput("t2_res_z", res_z, 16'hF448);

        // All four requesting from pointer 0.
        applyStimulus(0, 0);
        rst_n = 1'b0;
        applyStimulus(0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'hF, 0);
            #1 checkOutput("t3_grant", req_ready, 4'b0001 << (i % 4));
        end
        repeat (L + 4) applyStimulus(0, 0);

        // Wrap from pointer 3 and inflight build-up.
        applyStimulus(4'b0100, 0);
        repeat (L + 4) applyStimulus(0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1001, 0);
            #1 checkOutput("t4_grant", req_ready, (i % 2 == 0) ? 4'b1000 : 4'b0001);
        end
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        #1 checkOutput("t4_inflight8", inflight, 8);
        repeat (L + 4) applyStimulus(0, 0);

        // Hold for 5 cycles with 6 ops in flight.
        applyStimulus(4'b0001, 0);
        t0 = cyc;
        for (int i = 0; i < 5; i++) applyStimulus(4'b0110, 0);
        repeat (3) applyStimulus(0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'hF, 1);
            #1 checkOutput("t5_hold_ready", req_ready, 0);
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0);
            if (res_valid != 0) begin seen = 1'b1; break; end
        end
        checkOutput("t5_first_result_seen", seen, 1);
        checkOutput("t5_first_result_delay", cyc - t0, L + 2 + 5);
        repeat (L + 4) applyStimulus(0, 0);

        // Randomized traffic with occasional hold.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(N'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
        end
        repeat (L + 6) applyStimulus(0, 0);

        // Reset with 10 ops in flight.
        repeat (10) applyStimulus(4'hF, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkOutput("t1_res_valid", res_valid, 0);
        checkOutput("t1_inflight", inflight, 0);
        checkOutput("t1_valid_in", cordic_valid_in, 0);
        applyStimulus(0, 0);
        rst_n = 1'b1;
        repeat (L + 6) applyStimulus(0, 0);
        #1 checkOutput("t1_inflight_after", inflight, 0);

        // Drop one CORDIC valid while a tag is due.
        applyStimulus(4'b0010, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0);
            if (fv[L-1]) begin dropValid = 1'b1; seen = 1'b1; break; end
        end
        checkOutput("t6_slot_seen", seen, 1);
        applyStimulus(0, 0);
        #1 checkOutput("t6_sync_err_set", sync_err, 1);
        checkOutput("t6_still_routed", res_valid, 4'b0010);
        repeat (5) applyStimulus(0, 0);
        #1 checkOutput("t6_sync_err_sticky", sync_err, 1);
        applyStimulus(0, 0);
        rst_n = 1'b0;
        applyStimulus(0, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0);
        #1 checkOutput("t6_sync_err_cleared", sync_err, 0);
        applyStimulus(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
